// File: rtl/pong_score_datapath.sv
// Score, rally-hit, speed-level and ball-step tick datapath for the 2-player Pong controller.
// All state is synchronous to Clk; Rst_n is a synchronous active-low reset.
module pong_score_datapath #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int HIT_W        = 8,
    parameter int HITS_PER_LVL = 4,
    parameter int MAX_LVL      = 3,
    parameter int TICK_BASE    = 50000000,
    parameter int TICK_DEC     = 10000000
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               P1_ld,
    input  logic               P1_clr,
    input  logic               P2_ld,
    input  logic               P2_clr,
    input  logic               Hit_ld,
    input  logic               Hit_clr,
    input  logic               Lvl_clr,
    input  logic               Step_en,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               winner,
    output logic               win_p2,
    output logic               tie,
    output logic [HIT_W-1:0]   hit_cnt,
    output logic [1:0]         level,
    output logic               step_tick
);

    localparam int LVL_W  = 2;
    localparam int PROG_W = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL) : 1;
    localparam int CNT_W  = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [HIT_W-1:0]   HIT_MAX   = {HIT_W{1'b1}};
    localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(MAX_LVL);
    localparam logic [PROG_W-1:0]  PROG_LAST = PROG_W'(HITS_PER_LVL - 1);

    logic [SCORE_W-1:0] r_p1;
    logic [SCORE_W-1:0] r_p2;
    logic [HIT_W-1:0]   r_hit;
    logic [PROG_W-1:0]  r_prog;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tick;

    logic               w_p1_win;
    logic               w_p2_win;
    logic               w_winner;
    logic [31:0]        w_period_m1;
    logic               w_cnt_last;

    // Result decode is purely from registered scores, so it trails the ld edge by one cycle.
    assign w_p1_win = (r_p1 == WIN_VAL);
    assign w_p2_win = (r_p2 == WIN_VAL);
    assign w_winner = w_p1_win | w_p2_win;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_p1 <= '0;
        end else if (P1_clr) begin
            r_p1 <= '0;
        end else if (P1_ld && !w_winner && (r_p1 < WIN_VAL)) begin
            r_p1 <= r_p1 + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_p2 <= '0;
        end else if (P2_clr) begin
            r_p2 <= '0;
        end else if (P2_ld && !w_winner && (r_p2 < WIN_VAL)) begin
            r_p2 <= r_p2 + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_hit <= '0;
        end else if (Hit_clr) begin
            r_hit <= '0;
        end else if (Hit_ld && (r_hit != HIT_MAX)) begin
            r_hit <= r_hit + 1'b1;
        end
    end

    // Progress always wraps on the last hit of a level, even once the level has saturated.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_prog  <= '0;
            r_level <= '0;
        end else if (Lvl_clr) begin
            r_prog  <= '0;
            r_level <= '0;
        end else if (Hit_clr) begin
            r_prog  <= '0;
        end else if (Hit_ld) begin
            if (r_prog == PROG_LAST) begin
                r_prog <= '0;
                if (r_level != LVL_MAX) begin
                    r_level <= r_level + 1'b1;
                end
            end else begin
                r_prog <= r_prog + 1'b1;
            end
        end
    end

    // ">=" rather than "==" lets a level raise that shortens the period below the
    // current count wrap on the next cycle instead of running off to the counter limit.
    assign w_period_m1 = 32'(TICK_BASE) - (32'(r_level) * 32'(TICK_DEC)) - 32'd1;
    assign w_cnt_last  = (32'(r_cnt) >= w_period_m1);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!Step_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_cnt_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign p1_score  = r_p1;
    assign p2_score  = r_p2;
    assign winner    = w_winner;
    assign tie       = w_p1_win & w_p2_win;
    assign win_p2    = w_p2_win & ~w_p1_win;
    assign hit_cnt   = r_hit;
    assign level     = r_level;
    assign step_tick = r_tick;

endmodule

// File: tb/tb_pong_score_datapath.sv
// Bench for pong_score_datapath: a table of single-cycle vectors plus hand-written
// multi-cycle tick sequences, all checked through an expected-value queue.
module tb_pong_score_datapath;

    localparam int SCORE_W = 4;
    localparam int HIT_W   = 8;
    localparam int OUT_W   = 2*SCORE_W + 3 + HIT_W + 2 + 1;

    // Input vector bit assignments: {rst_n, p1_ld, p1_clr, p2_ld, p2_clr, hit_ld, hit_clr, lvl_clr, step_en}
    localparam logic [8:0] RN  = 9'h100;
    localparam logic [8:0] P1L = 9'h080;
    localparam logic [8:0] P1C = 9'h040;
    localparam logic [8:0] P2L = 9'h020;
    localparam logic [8:0] P2C = 9'h010;
    localparam logic [8:0] HL  = 9'h008;
    localparam logic [8:0] HC  = 9'h004;
    localparam logic [8:0] LC  = 9'h002;
    localparam logic [8:0] SE  = 9'h001;

    logic clk;
    logic rst_n, p1_ld, p1_clr, p2_ld, p2_clr, hit_ld, hit_clr, lvl_clr, step_en;
    logic [SCORE_W-1:0] p1_score, p2_score;
    logic winner, win_p2, tie, step_tick;
    logic [HIT_W-1:0] hit_cnt;
    logic [1:0] level;

    logic [OUT_W-1:0] exp_q[$];
    int n_cmp;
    int n_fail;

    typedef struct {
        logic [8:0]       in;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t tbl[30];

    pong_score_datapath #(
        .SCORE_W(SCORE_W), .WIN_SCORE(3), .HIT_W(HIT_W), .HITS_PER_LVL(2),
        .MAX_LVL(3), .TICK_BASE(8), .TICK_DEC(2)
    ) dut (
        .Clk(clk), .Rst_n(rst_n),
        .P1_ld(p1_ld), .P1_clr(p1_clr), .P2_ld(p2_ld), .P2_clr(p2_clr),
        .Hit_ld(hit_ld), .Hit_clr(hit_clr), .Lvl_clr(lvl_clr), .Step_en(step_en),
        .p1_score(p1_score), .p2_score(p2_score),
        .winner(winner), .win_p2(win_p2), .tie(tie),
        .hit_cnt(hit_cnt), .level(level), .step_tick(step_tick)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ev(int p1, int p2, bit w, bit wp2, bit t,
                                             int hit, int lvl, bit tick);
        return {SCORE_W'(p1), SCORE_W'(p2), w, wp2, t, HIT_W'(hit), 2'(lvl), tick};
    endfunction

    // Driver: apply one cycle of inputs, queue its expected outputs, check after the edge.
    task automatic cyc(input logic [8:0] in, input logic [OUT_W-1:0] exp, input string tag);
        logic [OUT_W-1:0] act;
        logic [OUT_W-1:0] want;
        @(negedge clk);
        {rst_n, p1_ld, p1_clr, p2_ld, p2_clr, hit_ld, hit_clr, lvl_clr, step_en} = in;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        act  = {p1_score, p2_score, winner, win_p2, tie, hit_cnt, level, step_tick};
        want = exp_q.pop_front();
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got p1=%0d p2=%0d win=%b wp2=%b tie=%b hit=%0d lvl=%0d tick=%b, want p1=%0d p2=%0d win=%b wp2=%b tie=%b hit=%0d lvl=%0d tick=%b",
                     tag, act[20:17], act[16:13], act[12], act[11], act[10], act[9:2], act[1:0], act[0],
                     want[20:17], want[16:13], want[12], want[11], want[10], want[9:2], want[1:0], want[0]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        {rst_n, p1_ld, p1_clr, p2_ld, p2_clr, hit_ld, hit_clr, lvl_clr, step_en} = '0;

        tbl[0]  = '{P1L|P1C|P2L|P2C|HL|HC|LC|SE, ev(0,0,0,0,0,0,0,0)};
        tbl[1]  = '{RN,            ev(0,0,0,0,0,0,0,0)};
        tbl[2]  = '{RN|P2L,        ev(0,1,0,0,0,0,0,0)};
        tbl[3]  = '{RN|P2L,        ev(0,2,0,0,0,0,0,0)};
        tbl[4]  = '{RN|P2L,        ev(0,3,1,1,0,0,0,0)};
        tbl[5]  = '{RN|P2L|P1L,    ev(0,3,1,1,0,0,0,0)};
        tbl[6]  = '{RN|P2C|P2L,    ev(0,0,0,0,0,0,0,0)};
        tbl[7]  = '{RN|P1L,        ev(1,0,0,0,0,0,0,0)};
        tbl[8]  = '{RN|P1L,        ev(2,0,0,0,0,0,0,0)};
        tbl[9]  = '{RN|P2L,        ev(2,1,0,0,0,0,0,0)};
        tbl[10] = '{RN|P2L,        ev(2,2,0,0,0,0,0,0)};
        tbl[11] = '{RN|P1L|P2L,    ev(3,3,1,0,1,0,0,0)};
        tbl[12] = '{RN|P1C|P2C,    ev(0,0,0,0,0,0,0,0)};
        tbl[13] = '{RN|P1C|P1L,    ev(0,0,0,0,0,0,0,0)};
        tbl[14] = '{RN|HL,         ev(0,0,0,0,0,1,0,0)};
        tbl[15] = '{RN|HL,         ev(0,0,0,0,0,2,1,0)};
        tbl[16] = '{RN|HL,         ev(0,0,0,0,0,3,1,0)};
        tbl[17] = '{RN|HL,         ev(0,0,0,0,0,4,2,0)};
        tbl[18] = '{RN|HL,         ev(0,0,0,0,0,5,2,0)};
        tbl[19] = '{RN|HL,         ev(0,0,0,0,0,6,3,0)};
        tbl[20] = '{RN|HL,         ev(0,0,0,0,0,7,3,0)};
        tbl[21] = '{RN|HC,         ev(0,0,0,0,0,0,3,0)};
        tbl[22] = '{RN|HC|HL,      ev(0,0,0,0,0,0,3,0)};
        tbl[23] = '{RN|HL,         ev(0,0,0,0,0,1,3,0)};
        tbl[24] = '{RN|LC,         ev(0,0,0,0,0,1,0,0)};
        tbl[25] = '{RN|HL,         ev(0,0,0,0,0,2,0,0)};
        tbl[26] = '{RN|HL|LC,      ev(0,0,0,0,0,3,0,0)};
        tbl[27] = '{RN|HL,         ev(0,0,0,0,0,4,0,0)};
        tbl[28] = '{RN|HL|P1L,     ev(1,0,0,0,0,5,1,0)};
        tbl[29] = '{P1L|P2L|HL,    ev(0,0,0,0,0,0,0,0)};

        for (int i = 0; i < 30; i++) begin
            cyc(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Hit counter saturation: level follows every 2nd hit up to 3.
        for (int i = 1; i <= 256; i++) begin
            cyc(RN|HL, ev(0,0,0,0,0, (i > 255) ? 255 : i, (i/2 > 3) ? 3 : i/2, 0), $sformatf("hitsat%0d", i));
        end

        // Level-0 tick period of 8, then Step_en low gives no ticks.
        cyc(RN|HC|LC, ev(0,0,0,0,0,0,0,0), "clr_all");
        for (int k = 1; k <= 17; k++) begin
            cyc(RN|SE, ev(0,0,0,0,0,0,0, (k % 8) == 0), $sformatf("tick_l0_%0d", k));
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(RN, ev(0,0,0,0,0,0,0,0), $sformatf("step_off_%0d", k));
        end

        // Level-3 tick period of 2.
        for (int k = 1; k <= 6; k++) begin
            cyc(RN|HL, ev(0,0,0,0,0,k,(k/2 > 3) ? 3 : k/2,0), $sformatf("lvl_up_%0d", k));
        end
        for (int k = 1; k <= 6; k++) begin
            cyc(RN|SE, ev(0,0,0,0,0,6,3, (k % 2) == 0), $sformatf("tick_l3_%0d", k));
        end
        cyc(RN|HC|LC, ev(0,0,0,0,0,0,0,0), "clr_all2");

        // Level raise mid-count: level 1 (P=6) count at 4, Hit_ld lifts to level 2 (P=4).
        cyc(RN|HL, ev(0,0,0,0,0,1,0,0), "mid_h1");
        cyc(RN|HL, ev(0,0,0,0,0,2,1,0), "mid_h2");
        cyc(RN|HL, ev(0,0,0,0,0,3,1,0), "mid_h3");
        for (int k = 1; k <= 4; k++) begin
            cyc(RN|SE, ev(0,0,0,0,0,3,1,0), $sformatf("mid_cnt%0d", k));
        end
        cyc(RN|SE|HL, ev(0,0,0,0,0,4,2,0), "mid_raise");
        cyc(RN|SE, ev(0,0,0,0,0,4,2,1), "mid_wrap_tick");
        for (int k = 1; k <= 4; k++) begin
            cyc(RN|SE, ev(0,0,0,0,0,4,2, k == 4), $sformatf("mid_l2_%0d", k));
        end
        cyc(RN|SE, ev(0,0,0,0,0,4,2,0), "mid_pre_rst1");
        cyc(RN|SE, ev(0,0,0,0,0,4,2,0), "mid_pre_rst2");

        // Reset mid-count: counter restarts, so the next tick is a full level-0 period away.
        cyc(SE|HL|P1L, ev(0,0,0,0,0,0,0,0), "mid_rst");
        for (int k = 1; k <= 8; k++) begin
            cyc(RN|SE, ev(0,0,0,0,0,0,0, k == 8), $sformatf("post_rst_%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
